// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - funct3 codes, pending-load tag and lane extraction for the friscv load/store unit
package friscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [2:0] off;
    } lsu_tag_t;

    localparam int TAG_W = $bits(lsu_tag_t);

    // Works on a 64-bit view; a 32-bit datapath zero-extends rdata and truncates the result.
    function automatic logic [63:0] lane_extract(input logic [63:0] rdata,
                                                 input logic [2:0]  funct3,
                                                 input logic [2:0]  off);
        logic [63:0] lane;
        lane = rdata >> {off, 3'b000};
        case (funct3)
            LB:      lane_extract = {{56{lane[7]}}, lane[7:0]};
            LH:      lane_extract = {{48{lane[15]}}, lane[15:0]};
            LW:      lane_extract = {{32{lane[31]}}, lane[31:0]};
            LBU:     lane_extract = {56'b0, lane[7:0]};
            LHU:     lane_extract = {48'b0, lane[15:0]};
            LWU:     lane_extract = {32'b0, lane[31:0]};
            default: lane_extract = lane;
        endcase
    endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// rtl/friscv_scfifo.sv - single-clock FIFO holding the tags of loads awaiting a response
module friscv_scfifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge aclk) begin
        if (do_wr)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (srst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr)
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            if (do_rd)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/friscv_lsu.sv
// rtl/friscv_lsu.sv - load/store unit: decodes, checks and issues byte-strobed requests,
// tracking outstanding loads so responses land in the right register with the right extension.
module friscv_lsu
    import friscv_pkg::*;
#(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int OSTDREQ = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              lsu_en,
    output logic              lsu_ready,
    input  logic              lsu_load,
    input  logic [2:0]        lsu_funct3,
    input  logic [4:0]        lsu_rd_addr,
    input  logic [XLEN-1:0]   lsu_rs1_val,
    input  logic [XLEN-1:0]   lsu_rs2_val,
    input  logic [11:0]       lsu_imm,
    output logic              lsu_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDRW-1:0]  mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_strb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rd_wr,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_val
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(OSTDREQ + 1);

    logic [ADDRW-1:0] ea;
    logic [2:0]       off;
    logic [7:0]       strb_base;
    logic             misaligned;
    logic             illegal;
    logic             bad;
    logic             accept;
    logic             stall;
    logic             load_in_req;
    logic             push;
    logic             pop;
    logic             post_reset;
    lsu_tag_t         req_tag;
    lsu_tag_t         head_tag;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    assign ea  = ADDRW'(lsu_rs1_val + {{(XLEN-12){lsu_imm[11]}}, lsu_imm});
    assign off = 3'(ea[OFFW-1:0]);

    always_comb begin
        strb_base  = 8'h01;
        misaligned = 1'b0;
        case (lsu_funct3[1:0])
            2'b00: strb_base = 8'h01;
            2'b01: begin strb_base = 8'h03; misaligned = off[0];        end
            2'b10: begin strb_base = 8'h0F; misaligned = |off[1:0];     end
            2'b11: begin strb_base = 8'hFF; misaligned = |off;          end
            default: ;
        endcase
    end

    assign illegal = (lsu_funct3 == 3'b111) || (!lsu_load && lsu_funct3[2]) ||
                     ((XLEN == 32) && (lsu_funct3 == LD || lsu_funct3 == LWU));
    assign bad     = misaligned | illegal;

    // Occupancy counts a load still sitting in the request register, from registered state only.
    assign stall       = mem_en & ~mem_ready;
    assign load_in_req = mem_en & ~mem_wr;
    assign lsu_ready   = !stall &&
                         ((CW+1)'(fifo_count) + (CW+1)'(load_in_req) < (CW+1)'(OSTDREQ));
    assign accept      = lsu_en & lsu_ready;
    assign push        = mem_en & mem_ready & ~mem_wr & ~fifo_full;
    assign pop         = mem_rvalid & ~fifo_empty;

    friscv_scfifo #(
        .DEPTH (OSTDREQ),
        .WIDTH (TAG_W)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .wr_en   (push),
        .wr_data (req_tag),
        .rd_en   (pop),
        .rd_data (head_tag),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lsu_err    <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_strb   <= '0;
            req_tag    <= '0;
            rd_wr      <= 1'b0;
            rd_addr    <= '0;
            rd_val     <= '0;
            post_reset <= 1'b1;
        end else if (srst) begin
            lsu_err    <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_strb   <= '0;
            req_tag    <= '0;
            rd_wr      <= 1'b0;
            rd_addr    <= '0;
            rd_val     <= '0;
            post_reset <= 1'b1;
        end else begin
            lsu_err <= accept & bad;
            if (accept && !bad) begin
                mem_en    <= 1'b1;
                mem_wr    <= ~lsu_load;
                mem_addr  <= ea & ~ADDRW'(NB - 1);
                mem_wdata <= XLEN'(64'(lsu_rs2_val) << {off, 3'b000});
                mem_strb  <= NB'(strb_base << off);
                req_tag   <= '{rd: lsu_rd_addr, funct3: lsu_funct3, off: off};
            end else if (!stall) begin
                mem_en <= 1'b0;
            end
            rd_wr <= pop;
            if (pop) begin
                rd_addr <= head_tag.rd;
                rd_val  <= XLEN'(lane_extract(64'(mem_rdata), head_tag.funct3, head_tag.off));
            end
            if (push)
                post_reset <= 1'b0;
        end
    end

    // Stray responses right after a reset belong to dropped loads and are expected.
    a_rvalid_with_tag : assert property (@(posedge aclk) disable iff (!aresetn || srst)
        !(mem_rvalid && fifo_empty && !post_reset));

endmodule

// File: tb/tb_friscv_lsu.sv
// tb/tb_friscv_lsu.sv - directed vector table plus hand sequences for back-pressure, stall and reset
`timescale 1ns/1ps
module tb_friscv_lsu;
    import friscv_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn, srst, lsu_en, lsu_ready, lsu_load, lsu_err;
    logic [2:0]  lsu_funct3;
    logic [4:0]  lsu_rd_addr, rd_addr;
    logic [31:0] lsu_rs1_val, lsu_rs2_val, mem_wdata, mem_rdata, rd_val;
    logic [11:0] lsu_imm;
    logic        mem_en, mem_wr, mem_ready, mem_rvalid, rd_wr;
    logic [15:0] mem_addr;
    logic [3:0]  mem_strb;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    friscv_lsu #(.ADDRW(16), .XLEN(32), .OSTDREQ(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .lsu_en(lsu_en), .lsu_ready(lsu_ready), .lsu_load(lsu_load),
        .lsu_funct3(lsu_funct3), .lsu_rd_addr(lsu_rd_addr),
        .lsu_rs1_val(lsu_rs1_val), .lsu_rs2_val(lsu_rs2_val), .lsu_imm(lsu_imm),
        .lsu_err(lsu_err), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val)
    );

    typedef struct {
        logic        load;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic        err;
        logic [15:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] rdval;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic load, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm);
        lsu_en = 1'b1; lsu_load = load; lsu_funct3 = f3; lsu_rd_addr = rd;
        lsu_rs1_val = rs1; lsu_rs2_val = rs2; lsu_imm = imm;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vt[i];
        @(negedge aclk);
        chk($sformatf("v%0d_ready", i), lsu_ready, 1);
        drive(v.load, v.f3, v.rd, v.rs1, v.rs2, v.imm);
        @(negedge aclk);
        lsu_en = 1'b0;
        chk($sformatf("v%0d_err", i), lsu_err, v.err);
        chk($sformatf("v%0d_mem_en", i), mem_en, !v.err);
        if (!v.err) begin
            chk($sformatf("v%0d_addr", i), mem_addr, v.addr);
            chk($sformatf("v%0d_strb", i), mem_strb, v.strb);
            chk($sformatf("v%0d_wdata", i), mem_wdata, v.wdata);
            chk($sformatf("v%0d_wr", i), mem_wr, !v.load);
        end
        @(negedge aclk);
        chk($sformatf("v%0d_err_pulse", i), lsu_err, 0);
        chk($sformatf("v%0d_mem_idle", i), mem_en, 0);
        if (v.load && !v.err) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
            @(negedge aclk);
            mem_rvalid = 1'b0;
            chk($sformatf("v%0d_rd_wr", i), rd_wr, 1);
            chk($sformatf("v%0d_rd_addr", i), rd_addr, v.rd);
            chk($sformatf("v%0d_rd_val", i), rd_val, v.rdval);
            @(negedge aclk);
        end
        chk($sformatf("v%0d_rd_wr_low", i), rd_wr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //         load  f3   rd  rs1            rs2            imm     err  addr     strb  wdata          rdata          rdval
        vt[0]  = '{1'b0, SW,  0,  32'h100,       32'hDEADBEEF,  12'h004, 0, 16'h0104, 4'hF, 32'hDEADBEEF, 32'h0,         32'h0};
        vt[1]  = '{1'b0, SB,  0,  32'h200,       32'h000000A5,  12'h003, 0, 16'h0200, 4'h8, 32'hA5000000, 32'h0,         32'h0};
        vt[2]  = '{1'b1, LB,  5,  32'h200,       32'h0,         12'h003, 0, 16'h0200, 4'h8, 32'h0,        32'hA5000000,  32'hFFFFFFA5};
        vt[3]  = '{1'b1, LBU, 6,  32'h200,       32'h0,         12'h003, 0, 16'h0200, 4'h8, 32'h0,        32'hA5000000,  32'h000000A5};
        vt[4]  = '{1'b1, LH,  1,  32'h100,       32'h0,         12'h001, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[5]  = '{1'b1, LD,  1,  32'h100,       32'h0,         12'h000, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[6]  = '{1'b0, SH,  0,  32'h300,       32'h00001234,  12'hFFE, 0, 16'h02FC, 4'hC, 32'h12340000, 32'h0,         32'h0};
        vt[7]  = '{1'b1, LH,  7,  32'h2FE,       32'h0,         12'h000, 0, 16'h02FC, 4'hC, 32'h0,        32'h80010000,  32'hFFFF8001};
        vt[8]  = '{1'b1, LHU, 8,  32'h2FE,       32'h0,         12'h000, 0, 16'h02FC, 4'hC, 32'h0,        32'h80010000,  32'h00008001};
        vt[9]  = '{1'b1, LW,  9,  32'h10,        32'h0,         12'hFF0, 0, 16'h0000, 4'hF, 32'h0,        32'h12345678,  32'h12345678};
        vt[10] = '{1'b0, SW,  0,  32'h102,       32'h1,         12'h000, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[11] = '{1'b1, 3'b111, 1, 32'h0,       32'h0,         12'h000, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[12] = '{1'b0, 3'b100, 0, 32'h0,       32'h0,         12'h000, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[13] = '{1'b1, LWU, 1,  32'h0,         32'h0,         12'h000, 1, 16'h0,    4'h0, 32'h0,        32'h0,         32'h0};
        vt[14] = '{1'b0, SB,  0,  32'h401,       32'hFFFFFF3C,  12'h000, 0, 16'h0400, 4'h2, 32'hFFFF3C00, 32'h0,         32'h0};
        vt[15] = '{1'b1, LB, 10,  32'h401,       32'h0,         12'h000, 0, 16'h0400, 4'h2, 32'h0,        32'h00007F00,  32'h0000007F};
        vt[16] = '{1'b0, SW,  0,  32'h1FFFC,     32'h00000055,  12'h004, 0, 16'h0000, 4'hF, 32'h00000055, 32'h0,         32'h0};

        aresetn = 1'b0; srst = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        drive(1'b0, 3'b0, 5'd0, 32'h0, 32'h0, 12'h0);
        lsu_en = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_ready", lsu_ready, 1);
        chk("rst_err", lsu_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_strb", mem_strb, 0);
        chk("rst_rd_wr", rd_wr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_val", rd_val, 0);

        for (int i = 0; i < 17; i++) run_vec(i);

        // Two loads fill the pending FIFO; the third must wait for a response.
        @(negedge aclk); drive(1'b1, LW, 5'd1, 32'h40, 32'h0, 12'h0);
        @(negedge aclk); chk("ost_ready_2nd", lsu_ready, 1); drive(1'b1, LW, 5'd2, 32'h44, 32'h0, 12'h0);
        @(negedge aclk); chk("ost_ready_low", lsu_ready, 0); drive(1'b1, LW, 5'd3, 32'h48, 32'h0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("ost_hold_ready", lsu_ready, 0);
            chk("ost_hold_mem_en", mem_en, 0);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        @(negedge aclk);
        chk("ost_rd1_wr", rd_wr, 1); chk("ost_rd1_addr", rd_addr, 1); chk("ost_rd1_val", rd_val, 32'h11);
        mem_rdata = 32'h22;
        @(negedge aclk);
        lsu_en = 1'b0; mem_rvalid = 1'b0;
        chk("ost_rd2_wr", rd_wr, 1); chk("ost_rd2_addr", rd_addr, 2); chk("ost_rd2_val", rd_val, 32'h22);
        chk("ost_ld3_en", mem_en, 1); chk("ost_ld3_addr", mem_addr, 16'h48);
        @(negedge aclk);
        chk("ost_rd_wr_gap", rd_wr, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h33;
        @(negedge aclk);
        mem_rvalid = 1'b0;
        chk("ost_rd3_addr", rd_addr, 3); chk("ost_rd3_val", rd_val, 32'h33);

        // Store under a 5-cycle memory stall.
        @(negedge aclk);
        mem_ready = 1'b0;
        drive(1'b0, SW, 5'd0, 32'h80, 32'hCAFEF00D, 12'h0);
        @(negedge aclk);
        lsu_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_mem_en", mem_en, 1); chk("stall_addr", mem_addr, 16'h80);
            chk("stall_wdata", mem_wdata, 32'hCAFEF00D); chk("stall_strb", mem_strb, 4'hF);
            chk("stall_wr", mem_wr, 1); chk("stall_ready", lsu_ready, 0);
            @(negedge aclk);
        end
        mem_ready = 1'b1;
        @(negedge aclk);
        chk("stall_done_en", mem_en, 0); chk("stall_done_ready", lsu_ready, 1);

        // Asynchronous reset with two loads pending; late responses are dropped.
        @(negedge aclk); drive(1'b1, LW, 5'd11, 32'h50, 32'h0, 12'h0);
        @(negedge aclk); drive(1'b1, LW, 5'd12, 32'h54, 32'h0, 12'h0);
        @(negedge aclk); lsu_en = 1'b0;
        @(negedge aclk);
        chk("arst_pre_ready", lsu_ready, 0);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("arst_in_ready", lsu_ready, 1); chk("arst_in_mem_en", mem_en, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        mem_rvalid = 1'b1; mem_rdata = 32'h99;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("arst_stray_rd_wr", rd_wr, 0);
        end
        mem_rvalid = 1'b0;
        chk("arst_fifo_empty", dut.fifo_empty, 1); chk("arst_ready", lsu_ready, 1);

        // Synchronous reset with one load pending.
        @(negedge aclk); drive(1'b1, LW, 5'd13, 32'h60, 32'h0, 12'h0);
        @(negedge aclk); lsu_en = 1'b0;
        @(negedge aclk);
        chk("srst_pending", dut.fifo_empty, 0);
        srst = 1'b1;
        @(negedge aclk);
        srst = 1'b0;
        chk("srst_fifo_empty", dut.fifo_empty, 1); chk("srst_ready", lsu_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        @(negedge aclk);
        mem_rvalid = 1'b0;
        chk("srst_stray_rd_wr", rd_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/friscv_lsu.md
# friscv_lsu

Parametrised load/store unit for the friscv core, the successor of the memory path inside the rv32i ALU. It sits between the instruction decoder and the data-memory port and turns LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD into byte-strobed memory requests. Unlike the ALU path, it keeps up to OSTDREQ loads in flight over a split request/response memory interface. It also supports XLEN 32 or 64, and flags misaligned or illegal accesses instead of issuing them.

## Interface
- ADDRW, 16, memory address width
- XLEN, 32, datapath width; legal values 32 or 64
- OSTDREQ, 2, maximum outstanding loads (≥1)

- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset, same effect as aresetn
- lsu_en  in  1  instruction valid
- lsu_ready  out  1  unit can accept; transfer when lsu_en & lsu_ready
- lsu_load  in  1  1 = load, 0 = store
- lsu_funct3  in  3  RISC-V funct3 width/sign code
- lsu_rd_addr  in  5  load destination register
- lsu_rs1_val  in  XLEN  base address
- lsu_rs2_val  in  XLEN  store data
- lsu_imm  in  12  signed offset
- lsu_err  out  1  one-cycle pulse: misaligned or illegal access dropped
- mem_en  out  1  request valid
- mem_wr  out  1  1 = write
- mem_addr  out  ADDRW  byte address, aligned down to XLEN/8
- mem_wdata  out  XLEN  lane-shifted store data
- mem_strb  out  XLEN/8  byte enables
- mem_ready  in  1  request accepted when mem_en & mem_ready
- mem_rvalid  in  1  read response valid, in request order
- mem_rdata  in  XLEN  read response data
- rd_wr  out  1  register write pulse
- rd_addr  out  5  register index
- rd_val  out  XLEN  extended load result

## Operation
- ea = (lsu_rs1_val + sext(lsu_imm)) truncated to ADDRW; off = ea[log2(XLEN/8)-1:0].
- Misaligned accesses are rejected:
  - half with off[0] ≠ 0
  - word with off[1:0] ≠ 0
  - double with off[2:0] ≠ 0
- Illegal accesses are rejected:
  - funct3 011 (LD/SD) or 110 (LWU) with XLEN=32
  - funct3 111
  - store funct3 ≥ 100
- On reject: lsu_err pulses, no mem_en, no rd_wr.
- Store request:
  - strb = {1,3,15,255} per size, shifted left by off.
  - wdata = rs2 shifted left by 8·off.
  - mem_wr=1.
  - Completes on mem_ready; no response is expected.
- Load request:
  - mem_wr=0; strb as for stores.
  - Tag {rd_addr, funct3, off} is pushed into the pending FIFO when the request is accepted by memory.
- Response:
  - mem_rvalid pops the FIFO head.
  - Extract the lane at off; sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU; LD passes through.
  - rd_addr = tag.rd.
- mem_rvalid while the FIFO is empty is ignored (a simulation assertion fires).
- Request register: mem_* stay stable while mem_en & !mem_ready.
- lsu_ready = !(mem_en & !mem_ready) & (pending count + load in request reg < OSTDREQ). Computed from registered state only, with no bypass from a same-cycle pop.
- Simultaneous push and pop keep the count unchanged.
- Memory handles stores and loads in order; the unit does not reorder.

## Timing
- Reset values of all outputs: lsu_ready=1 out of reset; lsu_err, mem_en, mem_wr, rd_wr = 0; mem_addr, mem_wdata, mem_strb, rd_addr, rd_val = 0; FIFO empty.
- Accept at cycle N → mem_en at N+1 (or lsu_err at N+1 if rejected).
- With mem_ready held high, throughput is one request per cycle.
- mem_rvalid at cycle M → rd_wr/rd_val at M+1, one cycle wide.
- rd_wr may coincide with a new acceptance.
- Reset (either) mid-operation drops the request register and all tags. Responses arriving after reset are ignored.

## Structure
- friscv_pkg holds:
  - funct3 constants LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  - the tag struct typedef
- Sub-module friscv_scfifo: synchronous FIFO of depth OSTDREQ, width 5+3+3, with full/empty flags, count, aclk/aresetn/srst.
- Lane extraction is a function in friscv_pkg.

## Test plan
- SW, XLEN=32, rs1=0x100, imm=4, rs2=0xDEADBEEF → mem_addr=0x104, strb=4'b1111, wdata=0xDEADBEEF, mem_wr=1, lsu_err=0.
- SB at off 3, rs2=0x000000A5 → strb=4'b1000, wdata=0xA5000000. Then LB from the same address with rdata=0xA5000000 → rd_val=0xFFFFFFA5; LBU → 0x000000A5.
- LH at ea=0x101 → lsu_err pulse one cycle later, no mem_en, no rd_wr. LD with XLEN=32 → lsu_err.
- OSTDREQ=2: three back-to-back LW to rd 1,2,3 with rvalid withheld → lsu_ready low after two accepted. Returning 0x11 then 0x22 → rd 1=0x11, rd 2=0x22 in order, then the third load issues.
- Hold mem_ready=0 for 5 cycles under a store → mem_* stable and lsu_ready=0 throughout. Release → store completes next cycle.
- Assert aresetn low with 2 loads pending, then release and drive mem_rvalid → no rd_wr, FIFO empty, lsu_ready=1.
